// File: rtl/digest_accum.sv
// SHA-2 chaining-value accumulator: adds compression results into H0..H(N-1) across a multi-block message.
// Optional SHA-224 mode (mode_224 port, SHA-224 IV, truncated digest) is enabled by defining DIGEST_ACCUM_SHA224_EN.
module digest_accum #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 8,
  parameter logic [WORD_W*NUM_WORDS-1:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
`ifdef DIGEST_ACCUM_SHA224_EN
  input  logic                          mode_224,
`endif
  input  logic                          blk_valid,
  input  logic                          blk_last,
  output logic                          blk_ready,
  input  logic [WORD_W*NUM_WORDS-1:0]   state_in,
  output logic [WORD_W*NUM_WORDS-1:0]   chain_out,
  output logic [WORD_W*NUM_WORDS-1:0]   digest,
  output logic                          digest_valid,
  input  logic                          digest_ready,
  output logic                          busy,
  output logic [CNT_W-1:0]              blk_count
);

  localparam int unsigned H_W = WORD_W * NUM_WORDS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ABSORB = 2'd1;
  localparam logic [1:0] S_FINAL  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]     state_q;
  logic [H_W-1:0] h_q;
  logic [H_W-1:0] h_sum;
  logic [H_W-1:0] start_iv;
  logic [H_W-1:0] final_digest;
  logic           accept;

`ifdef DIGEST_ACCUM_SHA224_EN
  localparam logic [H_W-1:0] IV_224 =
    256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;

  logic mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      mode_q <= mode_224;
    end
  end

  assign start_iv     = mode_224 ? IV_224 : IV;
  // SHA-224 publishes only H0..H6, so the least-significant word is blanked.
  assign final_digest = mode_q ? {h_q[H_W-1:WORD_W], {WORD_W{1'b0}}} : h_q;
`else
  assign start_iv     = IV;
  assign final_digest = h_q;
`endif

  assign blk_ready = (state_q == S_ABSORB);
  assign busy      = (state_q != S_IDLE);
  assign chain_out = h_q;
  assign accept    = blk_valid && blk_ready;

  // Word-wise modular add; each slice truncates its own carry.
  always_comb begin
    h_sum = '0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      h_sum[i*WORD_W +: WORD_W] = h_q[i*WORD_W +: WORD_W] + state_in[i*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      h_q          <= IV;
      digest       <= '0;
      digest_valid <= 1'b0;
      blk_count    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            h_q       <= start_iv;
            blk_count <= '0;
            state_q   <= S_ABSORB;
          end
        end
        S_ABSORB: begin
          if (accept) begin
            h_q <= h_sum;
            if (blk_count != {CNT_W{1'b1}}) begin
              blk_count <= blk_count + CNT_W'(1);
            end
            if (blk_last) begin
              state_q <= S_FINAL;
            end
          end
        end
        S_FINAL: begin
          digest       <= final_digest;
          digest_valid <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          if (digest_valid && digest_ready) begin
            digest_valid <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digest_accum.sv
// Scoreboard bench for digest_accum: expected digests are queued as messages are issued and
// popped by a monitor on every digest handshake; a CNT_W=2 twin checks count saturation.
module tb_digest_accum;

  localparam logic [255:0] IV_256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ONES  = {8{32'hffffffff}};
  localparam logic [255:0] INC1  = {8{32'h00000001}};

  typedef struct {
    logic [255:0] digest;
    logic [15:0]  count;
  } exp_t;

  exp_t exp_q[$];

  logic         clk;
  logic         rst;
  logic         start;
  logic         blk_valid;
  logic         blk_last;
  logic [255:0] state_in;
  logic         digest_ready;
`ifdef DIGEST_ACCUM_SHA224_EN
  logic         mode_224;
`endif

  logic         blk_ready;
  logic [255:0] chain_out;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;
  logic [15:0]  blk_count;

  logic         d2_blk_ready;
  logic [255:0] d2_chain_out;
  logic [255:0] d2_digest;
  logic         d2_digest_valid;
  logic         d2_busy;
  logic [1:0]   d2_blk_count;

  int checks   = 0;
  int failures = 0;

  digest_accum dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
`ifdef DIGEST_ACCUM_SHA224_EN
    .mode_224     (mode_224),
`endif
    .blk_valid    (blk_valid),
    .blk_last     (blk_last),
    .blk_ready    (blk_ready),
    .state_in     (state_in),
    .chain_out    (chain_out),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .busy         (busy),
    .blk_count    (blk_count)
  );

  digest_accum #(.CNT_W(2)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
`ifdef DIGEST_ACCUM_SHA224_EN
    .mode_224     (mode_224),
`endif
    .blk_valid    (blk_valid),
    .blk_last     (blk_last),
    .blk_ready    (d2_blk_ready),
    .state_in     (state_in),
    .chain_out    (d2_chain_out),
    .digest       (d2_digest),
    .digest_valid (d2_digest_valid),
    .digest_ready (digest_ready),
    .busy         (d2_busy),
    .blk_count    (d2_blk_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Presents one block and holds it until the accumulator takes it.
  task automatic applyStimulus(input logic [255:0] vec, input logic last);
    int n = 0;
    blk_valid = 1'b1;
    state_in  = vec;
    blk_last  = last;
    while (!blk_ready && n < 20) begin
      tick();
      n++;
    end
    if (!blk_ready) begin
      checkOutput("blk_ready_timeout", 256'(blk_ready), 256'(1));
    end
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    state_in  = '0;
  endtask

  task automatic startMsg();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_blk_ready", 256'(blk_ready), 256'(1));
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    checkOutput("return_to_idle", 256'(busy), 256'(0));
  endtask

  task automatic pushExp(input logic [255:0] d, input logic [15:0] c);
    exp_t e;
    e.digest = d;
    e.count  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every digest handshake must match the oldest outstanding message.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && digest_valid && digest_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_digest actual=%h required=none", digest);
        end else begin
          e = exp_q.pop_front();
          checkOutput("digest", digest, e.digest);
          checkOutput("digest_blk_count", 256'(blk_count), 256'(e.count));
        end
      end
    end
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    blk_valid    = 1'b0;
    blk_last     = 1'b0;
    state_in     = '0;
    digest_ready = 1'b1;
`ifdef DIGEST_ACCUM_SHA224_EN
    mode_224     = 1'b0;
`endif
    tick();
    tick();
    checkOutput("rst_busy", 256'(busy), 256'(0));
    checkOutput("rst_blk_ready", 256'(blk_ready), 256'(0));
    checkOutput("rst_digest_valid", 256'(digest_valid), 256'(0));
    checkOutput("rst_digest", digest, 256'(0));
    checkOutput("rst_blk_count", 256'(blk_count), 256'(0));
    checkOutput("rst_chain_out", chain_out, IV_256);
    rst = 1'b0;

    blk_valid = 1'b1;
    state_in  = ONES;
    tick();
    blk_valid = 1'b0;
    checkOutput("idle_ignores_blk", chain_out, IV_256);
    checkOutput("idle_busy", 256'(busy), 256'(0));

    // Single zero block: digest equals the IV, valid two cycles after accept.
    startMsg();
    pushExp(IV_256, 16'd1);
    applyStimulus('0, 1'b1);
    checkOutput("final_digest_valid_low", 256'(digest_valid), 256'(0));
    checkOutput("final_blk_ready_low", 256'(blk_ready), 256'(0));
    tick();
    checkOutput("done_digest_valid_high", 256'(digest_valid), 256'(1));
    waitIdle();

    // Two back-to-back all-ones blocks wrap every word by -2.
    startMsg();
    pushExp(256'h6a09e665bb67ae833c6ef370a54ff538510e527d9b05688a1f83d9a95be0cd17, 16'd2);
    applyStimulus(ONES, 1'b0);
    checkOutput("chain_after_one",
                chain_out, 256'h6a09e666bb67ae843c6ef371a54ff539510e527e9b05688b1f83d9aa5be0cd18);
    applyStimulus(ONES, 1'b1);
    waitIdle();

    // +1 everywhere, idle gap, then a block that overflows H0 to exactly 1.
    startMsg();
    pushExp(256'h00000001bb67ae863c6ef373a54ff53b510e52809b05688d1f83d9ac5be0cd1a, 16'd2);
    applyStimulus(INC1, 1'b0);
    tick();
    applyStimulus({32'h95f61999, 224'h0}, 1'b1);
    waitIdle();

    // Back-pressure: DONE holds while start/blk_valid are pulsed.
    digest_ready = 1'b0;
    startMsg();
    pushExp(IV_256, 16'd1);
    applyStimulus('0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      start     = 1'b1;
      blk_valid = 1'b1;
      blk_last  = 1'b1;
      state_in  = ONES;
      tick();
      checkOutput("stall_digest_valid", 256'(digest_valid), 256'(1));
      checkOutput("stall_digest", digest, IV_256);
      checkOutput("stall_blk_ready", 256'(blk_ready), 256'(0));
      checkOutput("stall_busy", 256'(busy), 256'(1));
      checkOutput("stall_chain", chain_out, IV_256);
    end
    digest_ready = 1'b1;
    tick();
    start     = 1'b0;
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    state_in  = '0;
    checkOutput("release_busy", 256'(busy), 256'(0));
    checkOutput("release_digest_valid", 256'(digest_valid), 256'(0));
    checkOutput("release_digest_kept", digest, IV_256);
    tick();
    checkOutput("handshake_start_ignored", 256'(busy), 256'(0));

    // Reset mid-message discards everything.
    startMsg();
    applyStimulus(INC1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", 256'(busy), 256'(0));
    checkOutput("midrst_blk_ready", 256'(blk_ready), 256'(0));
    checkOutput("midrst_digest_valid", 256'(digest_valid), 256'(0));
    checkOutput("midrst_digest", digest, 256'(0));
    checkOutput("midrst_blk_count", 256'(blk_count), 256'(0));
    checkOutput("midrst_chain_out", chain_out, IV_256);
    blk_valid = 1'b1;
    state_in  = INC1;
    tick();
    blk_valid = 1'b0;
    checkOutput("postrst_chain_out", chain_out, IV_256);
    checkOutput("postrst_blk_count", 256'(blk_count), 256'(0));

    // Five non-last blocks: the 2-bit counter saturates, H keeps adding.
    startMsg();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(INC1, 1'b0);
    end
    checkOutput("count_five", 256'(blk_count), 256'(5));
    checkOutput("sat_count", 256'(d2_blk_count), 256'(3));
    checkOutput("sat_chain",
                d2_chain_out, 256'h6a09e66cbb67ae8a3c6ef377a54ff53f510e52849b0568911f83d9b05be0cd1e);
    pushExp(256'h6a09e66cbb67ae8a3c6ef377a54ff53f510e52849b0568911f83d9b05be0cd1e, 16'd6);
    applyStimulus('0, 1'b1);
    waitIdle();

`ifdef DIGEST_ACCUM_SHA224_EN
    mode_224 = 1'b1;
    startMsg();
    mode_224 = 1'b0;
    pushExp(256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa700000000, 16'd1);
    applyStimulus('0, 1'b1);
    waitIdle();
`endif

    tick();
    tick();
    checkOutput("queue_empty", 256'(exp_q.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
